uart_tx_fifo: RTL

Parametrised successor to the single-byte UART transmitter. It buffers outgoing words in a FIFO and serialises them LSB-first onto txd. Frame format is configurable: data width, optional even/odd parity, and 1 or 2 stop bits. It sits between the host-side write port and the pin, and is paced by the one-cycle-per-bit baud_enable tick from the BRG.

---
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small FIFO feeding an LSB-first serialiser with
// configurable data width, optional parity and one or two stop bits.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_enable,
    input  logic                 t_enable,
    input  logic [DATA_BITS-1:0] data,
    output logic                 txd,
    output logic                 tbr,
    output logic                 tx_busy,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 overflow
);
    localparam int AW = CNT_W - 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BW-1:0]    LAST_BIT   = BW'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = (STOP_BITS == 2);
    localparam logic             HAS_PARITY = (PARITY_EN != 0);
    localparam logic             ODD        = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Handshake: a word is accepted on any clk edge with t_enable=1 and tbr=1;
    // t_enable with tbr=0 drops the word and latches overflow until reset.
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 wr_en;
    logic                 pop;
    logic                 have_word;
    logic [DATA_BITS-1:0] head;

    state_t               state;
    state_t               state_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_cnt_next;
    logic                 stop_cnt;
    logic                 stop_cnt_next;
    logic                 par_bit;
    logic                 par_bit_next;
    logic                 txd_next;
    logic                 busy_next;

    // tbr comes from the registered count, so a full FIFO rejects a write
    // even in the cycle that pops a word.
    assign tbr       = (fifo_count < FULL_COUNT);
    assign wr_en     = t_enable & tbr;
    assign have_word = (fifo_count != '0);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (t_enable && !tbr) begin
                overflow <= 1'b1;
            end
        end
    end

    // State register; txd and tx_busy are registered alongside it so the
    // line changes on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            par_bit  <= par_bit_next;
            txd      <= txd_next;
            tx_busy  <= busy_next;
        end
    end

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        par_bit_next  = par_bit;
        pop           = 1'b0;
        if (baud_enable) begin
            unique case (state)
                S_IDLE: begin
                    if (have_word) begin
                        pop        = 1'b1;
                        state_next = S_START;
                    end
                end
                S_START: begin
                    state_next = S_DATA;
                end
                S_DATA: begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = HAS_PARITY ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    state_next = S_STOP;
                end
                S_STOP: begin
                    if (stop_cnt == STOP_LAST) begin
                        // Back-to-back frames: launch straight from the last stop bit.
                        if (have_word) begin
                            pop        = 1'b1;
                            state_next = S_START;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
        if (state_next != S_STOP) begin
            stop_cnt_next = 1'b0;
        end
        if (pop) begin
            shreg_next   = head;
            bit_cnt_next = '0;
            par_bit_next = (^head) ^ ODD;
        end
    end

    always_comb begin
        txd_next  = 1'b1;
        busy_next = 1'b1;
        unique case (state_next)
            S_IDLE:   busy_next = 1'b0;
            S_START:  txd_next  = 1'b0;
            S_DATA:   txd_next  = shreg_next[0];
            S_PARITY: txd_next  = par_bit_next;
            S_STOP:   txd_next  = 1'b1;
            default:  busy_next = 1'b0;
        endcase
    end

endmodule
